keypad_number_entry: RTL and testbench
======================================

KEYPAD_NUMBER_ENTRY -- requirements
Module: keypad_number_entry

Interface
REQ-001 Parameter: DATA_W, default 32, width of the entered/committed value (8..32).
REQ-002 Parameter: MAX_DIGITS, default 8, maximum digits held in one entry (1..10).
REQ-003 Parameter: DEC_EN, default 1; 0 disables decimal mode, and mode_dec is treated as 0.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 scan_valid  in  1  one-cycle strobe: scan_code holds a new PS/2 byte.
REQ-007 scan_code  in  8  PS/2 set-2 byte.
REQ-008 mode_dec  in  1  entry radix: 0 hex, 1 decimal.
REQ-009 num_ready  in  1  consumer accepts num_data.
REQ-010 num_data  out  DATA_W  committed value, two's complement when negative.
REQ-011 num_valid  out  1  num_data valid; held until handshake.
REQ-012 entry_data  out  DATA_W  live unsigned magnitude of the entry in progress.
REQ-013 digit_count  out  $clog2(MAX_DIGITS+1)  digits currently held.
REQ-014 neg  out  1  pending sign of the entry.
REQ-015 busy  out  1  decimal recalculation in progress.
REQ-016 err  out  1  one-cycle pulse on any rejected key.

Function
REQ-017 Parser FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); exactly one byte is consumed per scan_valid.
REQ-018 IDLE: F0->BRK; E0->EXT; any other byte is a make code, acted on in the same cycle and the FSM stays in IDLE.
REQ-019 BRK and EXT_BRK: the next byte is discarded and the FSM returns to IDLE, so break codes never act.
REQ-020 EXT: F0->EXT_BRK; 5A is treated as Enter; any other byte is ignored; the FSM returns to IDLE.
REQ-021 Typematic repeats (a repeated make without a break) each act as a new key press.
REQ-022 Digit codes: 45,16,1E,26,25,2E,36,3D,3E,46 are 0-9; 1C,32,21,23,24,2B are A-F; A-F are ignored without err when the entry radix is decimal.
REQ-023 Entry radix is latched from mode_dec when digit_count goes 0->1; changes to mode_dec while digit_count>0 have no effect.
REQ-024 Hex digit: entry_data <= (entry_data<<4)|d, truncated to DATA_W; digit_count+1.
REQ-025 Decimal digit: entry_data <= entry_data*10+d; if the result exceeds 2^DATA_W-1, the digit is rejected, err pulses, and state is unchanged.
REQ-026 A digit arriving when digit_count==MAX_DIGITS is rejected and err pulses.
REQ-027 A per-digit buffer of MAX_DIGITS nibbles records the digits entered.
REQ-028 Backspace (66) when digit_count==0 does nothing (no err, no underflow).
REQ-029 Backspace in hex: entry_data >>= 4, digit_count-1, completed in a single cycle.
REQ-030 Backspace in decimal: digit_count-1, entry enters RECALC, and busy=1 for digit_count-1 cycles (minimum 1).
REQ-031 RECALC rebuilds entry_data from the buffer using one multiply-accumulate per cycle; entry_data is valid when busy falls.
REQ-032 Any scan_valid while busy=1 is dropped; err pulses; parser state is unchanged.
REQ-033 Minus (4E) toggles neg at any time.
REQ-034 Escape (76) clears entry_data, digit_count and neg, and aborts RECALC.
REQ-035 Enter when digit_count==0 is ignored.
REQ-036 Enter with num_valid=1 and num_ready=0 is rejected; err pulses; the entry is kept.
REQ-037 Accepted Enter: next cycle num_data = neg ? (-entry_data mod 2^DATA_W) : entry_data; num_valid=1; entry_data, digit_count and neg are cleared.
REQ-038 num_valid is cleared on the cycle after num_valid&&num_ready, unless an Enter is accepted in that same cycle, in which case num_valid stays 1 with the new data.

Reset
REQ-039 Reset sets num_data=0, num_valid=0, entry_data=0, digit_count=0, neg=0, busy=0, err=0, parser=IDLE, and clears the buffer.
REQ-040 Reset mid-RECALC or mid-prefix takes effect immediately; no partial commit.

Verification
REQ-041 Hex: 16, 1E, F0 1E, 2B, 5A -> num_data=0x12F, num_valid=1, digit_count=0; the break F0 1E adds no digit.
REQ-042 Decimal: 16, 1E, 26, 66 -> busy for 1 cycle, then entry_data=12; 5A -> num_data=0x0000000C.
REQ-043 Negative decimal: 4E, 2E, E0 5A -> num_data=0xFFFFFFFB.
REQ-044 Hex full: 9 digit keys with MAX_DIGITS=8 -> 9th key gives err pulse and entry_data is unchanged.
REQ-045 Handshake: commit 0x1 with num_ready=0; enter 2 then 5A -> err, first value held; raise num_ready -> num_valid drops; 5A -> num_data=0x2.
REQ-046 Decimal overflow with DATA_W=8: 2, 5, 6 -> 6 rejected with err, entry_data=25; assert rst_n low during RECALC -> all outputs zero.

Source files
------------

// File: rtl/keypad_number_entry_if.sv
// Keypad number entry bus: scan byte input, committed-value handshake and
// live entry status. The slave modport is the entry block, the master
// modport is whoever feeds scan codes and consumes committed numbers.
interface keypad_number_entry_if #(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 8
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic              scan_valid;
    logic [7:0]        scan_code;
    logic              mode_dec;
    logic              num_ready;
    logic [DATA_W-1:0] num_data;
    logic              num_valid;
    logic [DATA_W-1:0] entry_data;
    logic [CW-1:0]     digit_count;
    logic              neg;
    logic              busy;
    logic              err;

    modport master (
        output scan_valid, scan_code, mode_dec, num_ready,
        input  num_data, num_valid, entry_data, digit_count, neg, busy, err
    );

    modport slave (
        input  scan_valid, scan_code, mode_dec, num_ready,
        output num_data, num_valid, entry_data, digit_count, neg, busy, err
    );
endinterface

// File: rtl/keypad_number_entry.sv
// PS/2 set-2 keypad number entry: parses make/break/extended prefixes,
// accumulates hex or decimal digits, supports sign, backspace, escape and
// Enter, and hands committed values out through a valid/ready pair.
module keypad_number_entry #(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 8,
    parameter int DEC_EN     = 1
) (
    input logic clk,
    input logic rst_n,
    keypad_number_entry_if.slave bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_DIGITS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] K_BRK   = 8'hF0;
    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_BKSP  = 8'h66;
    localparam logic [7:0] K_MINUS = 8'h4E;
    localparam logic [7:0] K_ESC   = 8'h76;

    logic [1:0]        state;
    logic [DATA_W-1:0] entry;
    logic [CW-1:0]     count;
    logic [CW-1:0]     rc_idx;
    logic              neg_q;
    logic              busy_q;
    logic              err_q;
    logic              dec_q;
    logic [DATA_W-1:0] num_data_q;
    logic              num_valid_q;
    logic [3:0]        dbuf [MAX_DIGITS];

    logic              digit_hit;
    logic [3:0]        digit_val;
    logic              is_letter;
    logic              eff_dec;
    logic              key_act;
    logic [DATA_W+3:0] ext_entry;
    logic [DATA_W+3:0] dec_sum;
    logic              dec_ovf;
    logic [DATA_W-1:0] rc_sum;

    // Key decode, effective radix, and the two multiply-by-ten datapaths
    always_comb begin
        digit_hit = 1'b1;
        digit_val = 4'h0;
        case (bus.scan_code)
            8'h45: digit_val = 4'h0;
            8'h16: digit_val = 4'h1;
            8'h1E: digit_val = 4'h2;
            8'h26: digit_val = 4'h3;
            8'h25: digit_val = 4'h4;
            8'h2E: digit_val = 4'h5;
            8'h36: digit_val = 4'h6;
            8'h3D: digit_val = 4'h7;
            8'h3E: digit_val = 4'h8;
            8'h46: digit_val = 4'h9;
            8'h1C: digit_val = 4'hA;
            8'h32: digit_val = 4'hB;
            8'h21: digit_val = 4'hC;
            8'h23: digit_val = 4'hD;
            8'h24: digit_val = 4'hE;
            8'h2B: digit_val = 4'hF;
            default: digit_hit = 1'b0;
        endcase
        is_letter = digit_val > 4'd9;
        eff_dec   = (count == '0) ? (bus.mode_dec && (DEC_EN != 0)) : dec_q;
        ext_entry = {4'b0000, entry};
        dec_sum   = (ext_entry << 3) + (ext_entry << 1) + {{DATA_W{1'b0}}, digit_val};
        dec_ovf   = |dec_sum[DATA_W+3:DATA_W];
        rc_sum    = (entry << 3) + (entry << 1)
                  + {{(DATA_W-4){1'b0}}, dbuf[IW'(rc_idx)]};
        key_act   = bus.scan_valid && !busy_q &&
                    ((state == ST_IDLE && bus.scan_code != K_BRK && bus.scan_code != K_EXT) ||
                     (state == ST_EXT && bus.scan_code == K_ENTER));
    end

    // Prefix parser: one byte consumed per strobe, frozen while recalculating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (bus.scan_valid && !busy_q) begin
            case (state)
                ST_IDLE: begin
                    if (bus.scan_code == K_BRK)      state <= ST_BRK;
                    else if (bus.scan_code == K_EXT) state <= ST_EXT;
                end
                ST_EXT:  state <= (bus.scan_code == K_BRK) ? ST_EXT_BRK : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Entry datapath, decimal rebuild after backspace, and commit handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry       <= '0;
            count       <= '0;
            rc_idx      <= '0;
            neg_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            dec_q       <= 1'b0;
            num_data_q  <= '0;
            num_valid_q <= 1'b0;
            for (int unsigned i = 0; i < unsigned'(MAX_DIGITS); i++) dbuf[i] <= '0;
        end else begin
            err_q <= 1'b0;
            if (num_valid_q && bus.num_ready) num_valid_q <= 1'b0;

            // Rebuild: the oldest digit was preloaded on backspace, so only
            // count-1 multiply-accumulates remain (one busy cycle minimum).
            if (busy_q) begin
                if (rc_idx >= count) begin
                    busy_q <= 1'b0;
                end else begin
                    entry  <= rc_sum;
                    rc_idx <= rc_idx + 1'b1;
                    if (rc_idx == count - CW'(1)) busy_q <= 1'b0;
                end
                if (bus.scan_valid) err_q <= 1'b1;
            end

            if (key_act) begin
                if (digit_hit) begin
                    if (is_letter && eff_dec) begin
                        // letters carry no meaning in decimal entry
                    end else if (count == FULL || (eff_dec && dec_ovf)) begin
                        err_q <= 1'b1;
                    end else begin
                        entry <= eff_dec ? dec_sum[DATA_W-1:0]
                                         : {entry[DATA_W-5:0], digit_val};
                        dbuf[IW'(count)] <= digit_val;
                        count <= count + 1'b1;
                        if (count == '0) dec_q <= eff_dec;
                    end
                end else begin
                    case (bus.scan_code)
                        K_BKSP: begin
                            if (count != '0) begin
                                count <= count - 1'b1;
                                if (dec_q) begin
                                    busy_q <= 1'b1;
                                    rc_idx <= CW'(1);
                                    entry  <= (count >= CW'(2))
                                            ? {{(DATA_W-4){1'b0}}, dbuf[0]} : '0;
                                end else begin
                                    entry <= entry >> 4;
                                end
                            end
                        end
                        K_MINUS: neg_q <= ~neg_q;
                        K_ESC: begin
                            entry  <= '0;
                            count  <= '0;
                            neg_q  <= 1'b0;
                            busy_q <= 1'b0;
                        end
                        K_ENTER: begin
                            if (count != '0) begin
                                if (num_valid_q && !bus.num_ready) begin
                                    err_q <= 1'b1;
                                end else begin
                                    num_data_q  <= neg_q ? (~entry + 1'b1) : entry;
                                    num_valid_q <= 1'b1;
                                    entry       <= '0;
                                    count       <= '0;
                                    neg_q       <= 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.num_data    = num_data_q;
    assign bus.num_valid   = num_valid_q;
    assign bus.entry_data  = entry;
    assign bus.digit_count = count;
    assign bus.neg         = neg_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_keypad_number_entry.sv
// Testbench for keypad_number_entry: directed scenarios plus a randomized
// key stream checked against a digit-queue reference model.
module tb_keypad_number_entry;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] kc [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                            8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    keypad_number_entry_if #(.DATA_W(32), .MAX_DIGITS(8)) bus32 ();
    keypad_number_entry_if #(.DATA_W(8),  .MAX_DIGITS(8)) bus8 ();

    keypad_number_entry #(.DATA_W(32), .MAX_DIGITS(8), .DEC_EN(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32));
    keypad_number_entry #(.DATA_W(8), .MAX_DIGITS(8), .DEC_EN(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // all tasks start and end at a falling edge
    task automatic do_reset;
        rst_n = 1'b0;
        bus32.scan_valid = 0; bus32.scan_code = 0; bus32.mode_dec = 0; bus32.num_ready = 0;
        bus8.scan_valid  = 0; bus8.scan_code  = 0; bus8.mode_dec  = 0; bus8.num_ready  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse32(input logic [7:0] code, output logic e);
        bus32.scan_code = code; bus32.scan_valid = 1'b1;
        @(negedge clk);
        e = bus32.err; bus32.scan_valid = 1'b0;
    endtask

    task automatic key32(input logic [7:0] code, output logic e);
        int n;
        pulse32(code, e);
        @(negedge clk);
        n = 0;
        while (bus32.busy && n < 40) begin @(negedge clk); n++; end
        if (bus32.busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles, want 0", bus32.busy, n);
        end
    endtask

    task automatic pulse8(input logic [7:0] code, output logic e);
        bus8.scan_code = code; bus8.scan_valid = 1'b1;
        @(negedge clk);
        e = bus8.err; bus8.scan_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (bus32.num_data !== 32'h0)  begin errors++; $display("FAIL rst_num_data: got %h want 0", bus32.num_data); end
        checks++; if (bus32.num_valid !== 1'b0)  begin errors++; $display("FAIL rst_num_valid: got %b want 0", bus32.num_valid); end
        checks++; if (bus32.entry_data !== 32'h0) begin errors++; $display("FAIL rst_entry: got %h want 0", bus32.entry_data); end
        checks++; if (bus32.digit_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus32.digit_count); end
        checks++; if ({bus32.neg, bus32.busy, bus32.err} !== 3'b000)
            begin errors++; $display("FAIL rst_flags: got neg/busy/err %b want 000", {bus32.neg, bus32.busy, bus32.err}); end
    endtask

    task automatic test_hex;
        logic e;
        do_reset;
        bus32.mode_dec = 0; bus32.num_ready = 0;
        key32(8'h16, e); key32(8'h1E, e); key32(8'hF0, e); key32(8'h1E, e);
        checks++; if (bus32.digit_count !== 4'd2 || bus32.entry_data !== 32'h12)
            begin errors++; $display("FAIL hex_break: got count %0d entry %h want 2 / 12", bus32.digit_count, bus32.entry_data); end
        key32(8'h2B, e); key32(8'h5A, e);
        checks++; if (bus32.num_data !== 32'h12F || bus32.num_valid !== 1'b1 || bus32.digit_count !== 4'd0)
            begin errors++; $display("FAIL hex_commit: got data %h valid %b count %0d want 12F/1/0",
                                     bus32.num_data, bus32.num_valid, bus32.digit_count); end
    endtask

    task automatic test_decimal;
        logic e;
        int n;
        do_reset;
        bus32.mode_dec = 1; bus32.num_ready = 1;
        key32(8'h16, e); key32(8'h1E, e); key32(8'h26, e);
        checks++; if (bus32.entry_data !== 32'd123)
            begin errors++; $display("FAIL dec_entry: got %0d want 123", bus32.entry_data); end
        pulse32(8'h66, e);
        n = 0;
        while (bus32.busy && n < 40) begin n++; @(negedge clk); end
        checks++; if (n != 1) begin errors++; $display("FAIL dec_busy_len: got %0d cycles want 1", n); end
        checks++; if (bus32.entry_data !== 32'd12 || bus32.digit_count !== 4'd2)
            begin errors++; $display("FAIL dec_recalc: got %0d count %0d want 12 / 2", bus32.entry_data, bus32.digit_count); end
        key32(8'h5A, e);
        checks++; if (bus32.num_data !== 32'h0000000C)
            begin errors++; $display("FAIL dec_commit: got %h want 0000000C", bus32.num_data); end
    endtask

    task automatic test_busy_drop;
        logic e;
        do_reset;
        bus32.mode_dec = 1;
        key32(8'h16, e); key32(8'h1E, e); key32(8'h26, e);
        pulse32(8'h66, e);
        pulse32(8'h16, e);
        checks++; if (e !== 1'b1 || bus32.digit_count !== 4'd2 || bus32.entry_data !== 32'd12)
            begin errors++; $display("FAIL busy_drop: got err %b count %0d entry %0d want 1/2/12",
                                     e, bus32.digit_count, bus32.entry_data); end
    endtask

    task automatic test_negative;
        logic e;
        do_reset;
        bus32.mode_dec = 1; bus32.num_ready = 1;
        key32(8'h4E, e);
        checks++; if (bus32.neg !== 1'b1) begin errors++; $display("FAIL neg_toggle: got %b want 1", bus32.neg); end
        key32(8'h2E, e); key32(8'hE0, e); key32(8'h5A, e);
        checks++; if (bus32.num_data !== 32'hFFFFFFFB || bus32.neg !== 1'b0)
            begin errors++; $display("FAIL neg_commit: got %h neg %b want FFFFFFFB/0", bus32.num_data, bus32.neg); end
    endtask

    task automatic test_full;
        logic e;
        do_reset;
        bus32.mode_dec = 0;
        repeat (8) key32(8'h16, e);
        key32(8'h16, e);
        checks++; if (e !== 1'b1 || bus32.entry_data !== 32'h11111111 || bus32.digit_count !== 4'd8)
            begin errors++; $display("FAIL hex_full: got err %b entry %h count %0d want 1/11111111/8",
                                     e, bus32.entry_data, bus32.digit_count); end
    endtask

    task automatic test_handshake;
        logic e;
        do_reset;
        bus32.mode_dec = 0; bus32.num_ready = 0;
        key32(8'h16, e); key32(8'h5A, e);
        key32(8'h1E, e); key32(8'h5A, e);
        checks++; if (e !== 1'b1 || bus32.num_data !== 32'h1 || bus32.num_valid !== 1'b1 || bus32.digit_count !== 4'd1)
            begin errors++; $display("FAIL hs_reject: got err %b data %h valid %b count %0d want 1/1/1/1",
                                     e, bus32.num_data, bus32.num_valid, bus32.digit_count); end
        bus32.num_ready = 1;
        @(negedge clk);
        checks++; if (bus32.num_valid !== 1'b0) begin errors++; $display("FAIL hs_drop: got valid %b want 0", bus32.num_valid); end
        bus32.num_ready = 0;
        key32(8'h5A, e);
        checks++; if (bus32.num_data !== 32'h2 || bus32.num_valid !== 1'b1)
            begin errors++; $display("FAIL hs_second: got data %h valid %b want 2/1", bus32.num_data, bus32.num_valid); end
    endtask

    task automatic test_back_to_back;
        logic e;
        do_reset;
        bus32.mode_dec = 0; bus32.num_ready = 0;
        key32(8'h26, e); key32(8'h5A, e); key32(8'h25, e);
        bus32.num_ready = 1;
        pulse32(8'h5A, e);
        checks++; if (e !== 1'b0 || bus32.num_valid !== 1'b1 || bus32.num_data !== 32'h4)
            begin errors++; $display("FAIL b2b_commit: got err %b valid %b data %h want 0/1/4", e, bus32.num_valid, bus32.num_data); end
        @(negedge clk);
        checks++; if (bus32.num_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got valid %b want 0", bus32.num_valid); end
    endtask

    task automatic test_random;
        int       digs[$];
        bit       m_dec, m_neg, m_valid, skip, ext;
        logic [31:0] m_data;
        do_reset;
        m_dec = 0; m_neg = 0; m_valid = 0; skip = 0; ext = 0; m_data = 0;
        for (int it = 0; it < 400; it++) begin
            logic [7:0] code;
            logic e;
            bit rdy, md, exp_err, committed, act, dec;
            int r, d;
            longint unsigned v;
            r = $urandom_range(0, 99);
            if (r < 40)      code = kc[$urandom_range(0, 15)];
            else if (r < 50) code = 8'h66;
            else if (r < 55) code = 8'h4E;
            else if (r < 58) code = 8'h76;
            else if (r < 68) code = 8'h5A;
            else if (r < 74) code = 8'hF0;
            else if (r < 79) code = 8'hE0;
            else             code = 8'($urandom_range(0, 255));
            rdy = ($urandom_range(0, 2) != 0);
            md  = 1'($urandom_range(0, 1));
            exp_err = 0; committed = 0; act = 0;

            if (skip) skip = 0;
            else if (ext) begin
                ext = 0;
                if (code == 8'hF0) skip = 1;
                else if (code == 8'h5A) act = 1;
            end
            else if (code == 8'hF0) skip = 1;
            else if (code == 8'hE0) ext = 1;
            else act = 1;

            if (act) begin
                d = -1;
                for (int k = 0; k < 16; k++) if (kc[k] == code) d = k;
                v = 0;
                foreach (digs[k]) v = m_dec ? v * 10 + 64'(digs[k]) : ((v << 4) | 64'(digs[k])) & 64'hFFFFFFFF;
                if (d >= 0) begin
                    dec = (digs.size() == 0) ? md : m_dec;
                    if (d >= 10 && dec) ;
                    else if (digs.size() == 8) exp_err = 1;
                    else if (dec && v * 10 + 64'(d) > 64'hFFFFFFFF) exp_err = 1;
                    else begin
                        if (digs.size() == 0) m_dec = dec;
                        digs.push_back(d);
                    end
                end else if (code == 8'h66) begin
                    if (digs.size() > 0) void'(digs.pop_back());
                end else if (code == 8'h4E) m_neg = !m_neg;
                else if (code == 8'h76) begin digs.delete(); m_neg = 0; end
                else if (code == 8'h5A && digs.size() > 0) begin
                    if (m_valid && !rdy) exp_err = 1;
                    else begin
                        m_data = m_neg ? 32'(-v) : 32'(v);
                        committed = 1; digs.delete(); m_neg = 0;
                    end
                end
            end
            m_valid = rdy ? 1'b0 : (committed ? 1'b1 : m_valid);
            v = 0;
            foreach (digs[k]) v = m_dec ? v * 10 + 64'(digs[k]) : ((v << 4) | 64'(digs[k])) & 64'hFFFFFFFF;

            bus32.num_ready = rdy; bus32.mode_dec = md;
            key32(code, e);
            checks++; if (e !== exp_err) begin errors++; $display("FAIL rnd_err it=%0d code=%h: got %b want %b", it, code, e, exp_err); end
            checks++; if (bus32.entry_data !== 32'(v)) begin errors++; $display("FAIL rnd_entry it=%0d code=%h: got %h want %h", it, code, bus32.entry_data, 32'(v)); end
            checks++; if (bus32.digit_count !== 4'(digs.size())) begin errors++; $display("FAIL rnd_count it=%0d: got %0d want %0d", it, bus32.digit_count, digs.size()); end
            checks++; if (bus32.neg !== m_neg) begin errors++; $display("FAIL rnd_neg it=%0d: got %b want %b", it, bus32.neg, m_neg); end
            checks++; if (bus32.num_valid !== m_valid) begin errors++; $display("FAIL rnd_valid it=%0d: got %b want %b", it, bus32.num_valid, m_valid); end
            checks++; if (bus32.num_data !== m_data) begin errors++; $display("FAIL rnd_data it=%0d: got %h want %h", it, bus32.num_data, m_data); end
        end
    endtask

    task automatic test_overflow8;
        logic e;
        do_reset;
        bus8.mode_dec = 1; bus8.num_ready = 1;
        pulse8(8'h1E, e); pulse8(8'h2E, e); pulse8(8'h36, e);
        checks++; if (e !== 1'b1 || bus8.entry_data !== 8'd25 || bus8.digit_count !== 4'd2)
            begin errors++; $display("FAIL ovf8: got err %b entry %0d count %0d want 1/25/2", e, bus8.entry_data, bus8.digit_count); end
        bus8.scan_code = 8'h66; bus8.scan_valid = 1'b1;
        @(negedge clk);
        bus8.scan_valid = 1'b0;
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL ovf8_busy: got %b want 1", bus8.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus8.num_data, bus8.num_valid, bus8.entry_data, bus8.digit_count, bus8.neg, bus8.busy, bus8.err} !== '0)
            begin errors++; $display("FAIL ovf8_reset: got data %h valid %b entry %h count %0d neg %b busy %b err %b want all 0",
                                     bus8.num_data, bus8.num_valid, bus8.entry_data, bus8.digit_count, bus8.neg, bus8.busy, bus8.err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_hex;
        test_decimal;
        test_busy_drop;
        test_negative;
        test_full;
        test_handshake;
        test_back_to_back;
        test_random;
        test_overflow8;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
